mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 146 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl -- issue/sequencing controller for a multiply/divide unit.
//
// Decides in the E stage whether an MDU-class instruction issues, drives the
// start pulse and mode to the MDU, and tracks the fixed-latency operation in
// flight so the D stage can be frozen behind it.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst        : synchronous active-high reset, wins over every other input
//   e_valid    : E stage holds a valid MDU-class instruction
//   e_op       : 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo
//   e_div_zero : E-stage divisor is zero
//   flush      : kill the E-stage instruction this cycle
//   d_is_md    : D stage holds an MDU-class instruction
//   mdu_start  : start pulse to the MDU (same cycle as issue)
//   mdu_mod    : MDU mode, 7 when no command
//   busy       : operation in flight
//   stall_d    : freeze D stage
//   done       : pulse on the last busy cycle
//   dz_pulse   : pulse when a divide by zero is suppressed
//   err        : sticky protocol-violation flag
// ---------------------------------------------------------------------------
module mdu_ctrl #(
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       e_valid,
   input  logic [2:0] e_op,
   input  logic       e_div_zero,
   input  logic       flush,
   input  logic       d_is_md,
   output logic       mdu_start,
   output logic [2:0] mdu_mod,
   output logic       busy,
   output logic       stall_d,
   output logic       done,
   output logic       dz_pulse,
   output logic       err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
   localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);
   localparam logic [2:0] MOD_NONE = 3'd7;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic       issue_s;

   // Next-state, counter and command decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      mdu_start = 1'b0;
      mdu_mod   = MOD_NONE;
      done      = 1'b0;
      dz_pulse  = 1'b0;
      // Reset in the same cycle blocks any command from leaving the block.
      issue_s   = (state_q == ST_IDLE) && e_valid && !flush && !rst;

      case (state_q)
         ST_IDLE: begin
            if (issue_s) begin
               case (e_op)
                  3'd0, 3'd1: begin
                     mdu_start = 1'b1;
                     mdu_mod   = e_op;
                     state_d   = ST_MUL;
                     cnt_d     = MUL_CNT;
                  end
                  3'd2, 3'd3: begin
                     // A zero divisor never reaches the MDU; software is told
                     // through dz_pulse instead.
                     if (e_div_zero) begin
                        dz_pulse = 1'b1;
                     end else begin
                        mdu_start = 1'b1;
                        mdu_mod   = e_op;
                        state_d   = ST_DIV;
                        cnt_d     = DIV_CNT;
                     end
                  end
                  3'd4, 3'd5: begin
                     // Single-cycle moves: mode only, no start, no busy phase.
                     mdu_mod = e_op;
                  end
                  default: begin
                     mdu_mod = MOD_NONE;
                  end
               endcase
            end else begin
               mdu_mod = MOD_NONE;
            end
         end
         ST_MUL, ST_DIV: begin
            // flush is deliberately ignored here: the MDU has committed.
            if (cnt_q == 4'd1) begin
               done    = !rst;
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
            // Anything that would command the MDU while busy is a pipeline
            // protocol violation; reads (mfhi/mflo) are held off upstream.
            if (e_valid && (e_op <= 3'd5)) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // State, counter and sticky error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign busy    = (state_q != ST_IDLE);
   assign stall_d = d_is_md && (busy || mdu_start);
   assign err     = err_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus random traffic,
// all checked against a cycle-level reference model that tracks the number of
// busy cycles left rather than a state machine.
module tb_mdu_ctrl;

   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;

   logic       clk = 1'b0;
   logic       rst, e_valid, e_div_zero, flush, d_is_md;
   logic [2:0] e_op;
   logic       mdu_start, busy, stall_d, done, dz_pulse, err;
   logic [2:0] mdu_mod;

   int total = 0;
   int bad   = 0;

   // reference model state
   int rem   = 0;   // busy cycles still to come
   bit m_err = 0;

   int cyc_n    = 0;
   int done_at  = -1;
   int done_cnt = 0;
   int stall_cnt = 0;
   int t0;

   always #5 clk = ~clk;

   mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .rst(rst), .e_valid(e_valid), .e_op(e_op),
      .e_div_zero(e_div_zero), .flush(flush), .d_is_md(d_is_md),
      .mdu_start(mdu_start), .mdu_mod(mdu_mod), .busy(busy),
      .stall_d(stall_d), .done(done), .dz_pulse(dz_pulse), .err(err)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got=%0h exp=%0h", tag, cyc_n, got, exp);
      end
   endtask

   // One clock cycle: drive at negedge, compare combinational outputs, then
   // advance the model to what the next rising edge should produce.
   task automatic cyc(input bit r, input bit ev, input int op, input bit dz,
                      input bit fl, input bit dm);
      bit       is_mul, is_div, can_issue, e_start, e_dz, e_busy, e_done, e_stall;
      int       e_mod;
      @(negedge clk);
      rst = r; e_valid = ev; e_op = 3'(op); e_div_zero = dz; flush = fl; d_is_md = dm;
      #1;
      is_mul    = (op == 0) || (op == 1);
      is_div    = (op == 2) || (op == 3);
      e_busy    = (rem > 0);
      can_issue = !e_busy && ev && !fl && !r;
      e_start   = can_issue && (is_mul || (is_div && !dz));
      e_dz      = can_issue && is_div && dz;
      e_mod     = 7;
      if (e_start || (can_issue && (op == 4 || op == 5))) e_mod = op;
      e_done    = (rem == 1) && !r;
      e_stall   = dm && (e_busy || e_start);

      check_val("mdu_start", 32'(mdu_start), 32'(e_start));
      check_val("mdu_mod",   32'(mdu_mod),   32'(e_mod));
      check_val("busy",      32'(busy),      32'(e_busy));
      check_val("done",      32'(done),      32'(e_done));
      check_val("dz_pulse",  32'(dz_pulse),  32'(e_dz));
      check_val("stall_d",   32'(stall_d),   32'(e_stall));
      check_val("err",       32'(err),       32'(m_err));

      if (done === 1'b1) begin
         done_at = cyc_n;
         done_cnt++;
      end
      if (stall_d === 1'b1) stall_cnt++;

      if (r) begin
         rem = 0; m_err = 0;
      end else if (e_busy) begin
         if (ev && op <= 5) m_err = 1;
         rem--;
      end else if (e_start) begin
         rem = is_mul ? MUL_LAT : DIV_LAT;
      end
      cyc_n++;
   endtask

   task automatic idle(input int n, input bit dm);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, dm);
   endtask

   initial begin
      // unchecked power-on reset edge: DUT state is unknown before it
      rst = 1'b1; e_valid = 1'b0; e_op = 3'd0; e_div_zero = 1'b0;
      flush = 1'b0; d_is_md = 1'b0;
      @(posedge clk);
      cyc(1, 0, 0, 0, 0, 1);          // reset with d_is_md high: no stall
      idle(2, 0);

      // mult: start at 0, done at 5, idle at 6
      t0 = cyc_n; done_at = -1;
      cyc(0, 1, 0, 0, 0, 0);
      idle(7, 0);
      check_val("mul_done_cyc", 32'(done_at - t0), 32'd5);

      // div with D stage full the whole time: stall 11 cycles, done at 10
      t0 = cyc_n; done_at = -1; stall_cnt = 0;
      cyc(0, 1, 2, 0, 0, 1);
      idle(12, 1);
      check_val("div_done_cyc", 32'(done_at - t0), 32'd10);
      check_val("div_stall_len", 32'(stall_cnt), 32'd11);

      // divu by zero: suppressed, single pulse, stays idle
      cyc(0, 1, 3, 1, 0, 0);
      check_val("dz_seen", 32'(dz_pulse), 32'd1);
      idle(2, 0);

      // multu killed by flush
      cyc(0, 1, 1, 0, 1, 0);
      idle(1, 0);
      // mult then flush (with an mfhi) during its busy cycles
      t0 = cyc_n; done_at = -1;
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 1, 6, 0, 1, 0);
      idle(5, 0);
      check_val("flush_done_cyc", 32'(done_at - t0), 32'd5);

      // div injected while mult busy: err sticky, no restart
      t0 = cyc_n; done_at = -1;
      cyc(0, 1, 0, 0, 0, 0);
      idle(1, 0);
      cyc(0, 1, 2, 0, 0, 0);
      idle(6, 0);
      check_val("err_sticky", 32'(err), 32'd1);
      check_val("err_done_cyc", 32'(done_at - t0), 32'd5);
      cyc(1, 0, 0, 0, 0, 0);
      // mfhi injected instead: no error
      cyc(0, 1, 0, 0, 0, 0);
      idle(1, 0);
      cyc(0, 1, 6, 0, 0, 0);
      idle(6, 0);
      check_val("mfhi_no_err", 32'(err), 32'd0);

      // reset at cycle 3 of a div, then mthi immediately after
      done_cnt = 0;
      cyc(0, 1, 2, 0, 0, 0);
      idle(2, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 4, 0, 0, 0);
      check_val("mthi_mod", 32'(mdu_mod), 32'd4);
      idle(12, 0);
      check_val("rst_no_done", 32'(done_cnt), 32'd0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1),
             int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
